// File: rtl/acc_pkg.sv
// Shared definitions for the matrix-multiply engine and its bridge.
//   ACC_N / ACC_DATA_W : default matrix geometry shared with the bridge
//   state_t            : engine FSM states
//   acc_width()        : accumulator width that cannot overflow for an N-term dot product
package acc_pkg;

  localparam int ACC_N      = 32;
  localparam int ACC_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int acc_width(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/acc_matmul_core_if.sv
// Bridge <-> matmul engine bus.
//   start    : launch request (level, bridge -> engine)
//   acc_in_A : matrix A, row-major, element width DATA_W
//   acc_in_B : matrix B, row-major
//   acc_out  : matrix C, row-major (engine -> bridge)
//   busy     : engine computing
//   done     : one-cycle completion pulse
// master = bridge side, slave = engine side.
interface acc_matmul_core_if
  import acc_pkg::*;
#(
  parameter int N      = ACC_N,
  parameter int DATA_W = ACC_DATA_W
);

  logic                           start;
  logic [N*N-1:0][DATA_W-1:0]     acc_in_A;
  logic [N*N-1:0][DATA_W-1:0]     acc_in_B;
  logic [N*N-1:0][DATA_W-1:0]     acc_out;
  logic                           busy;
  logic                           done;

  modport master (
    output start, acc_in_A, acc_in_B,
    input  acc_out, busy, done
  );

  modport slave (
    input  start, acc_in_A, acc_in_B,
    output acc_out, busy, done
  );

endinterface

// File: rtl/acc_mac_unit.sv
// Single multiply-accumulate lane with output rule.
//   clk, rst : clock, synchronous active-high reset
//   en       : accumulate this cycle
//   clr      : start a new dot product (ignore the stored accumulator)
//   a, b     : unsigned operands
//   result   : out_rule(sum including this cycle's product), combinational,
//              truncated to DATA_W bits (SAT=0) or clamped to all-ones (SAT=1)
module acc_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [ACC_W-1:0]    acc_reg;
  logic [2*DATA_W-1:0] product;
  logic [ACC_W-1:0]    sum;
  logic                overflow;

  assign product = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign sum     = (clr ? '0 : acc_reg) + ACC_W'(product);

  // Only the clamping variant cares about the high bits of the sum.
  assign overflow = (SAT != 0) && (|sum[ACC_W-1:DATA_W]);
  assign result   = overflow ? {DATA_W{1'b1}} : sum[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/acc_matmul_core.sv
// Sequential matrix-multiply engine: C = A x B, one MAC per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of acc_matmul_core_if (start, A, B in; C, busy, done out)
// A run takes N^3 busy cycles followed by a one-cycle done pulse. C elements are
// written one per N cycles as their dot products complete.
// N must be a power of two: flat element indices are formed by concatenating
// row and column counters.
module acc_matmul_core
  import acc_pkg::*;
#(
  parameter int N      = ACC_N,
  parameter int DATA_W = ACC_DATA_W,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  acc_matmul_core_if.slave bus
);

  localparam int               IDX_W  = $clog2(N);
  localparam int               ELEM_W = 2 * IDX_W;
  localparam int               ACC_W  = acc_width(N, DATA_W);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  i_reg, i_next;
  logic [IDX_W-1:0]  j_reg, j_next;
  logic [IDX_W-1:0]  k_reg, k_next;
  logic              start_q_reg;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              launch;
  logic              mac_en;
  logic              wr_en;
  logic [ELEM_W-1:0] a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] mac_result;

  // start_q tracks start in every state, so a level held across the end of a
  // run is not seen as a new rising edge.
  assign launch = bus.start & ~start_q_reg;

  assign a_idx = {i_reg, k_reg};
  assign b_idx = {k_reg, j_reg};
  assign c_idx = {i_reg, j_reg};

  acc_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT    (SAT)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (mac_en),
    .clr    (k_reg == '0),
    .a      (bus.acc_in_A[a_idx]),
    .b      (bus.acc_in_B[b_idx]),
    .result (mac_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      i_reg       <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      start_q_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      i_reg       <= i_next;
      j_reg       <= j_next;
      k_reg       <= k_next;
      start_q_reg <= bus.start;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    mac_en     = 1'b0;
    wr_en      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = RUN;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        mac_en = 1'b1;
        if (k_reg == LAST) begin
          // Last term of C[i][j]: commit it and step k -> j -> i.
          wr_en  = 1'b1;
          k_next = '0;
          if (j_reg == LAST) begin
            j_next = '0;
            if (i_reg == LAST) begin
              i_next     = '0;
              state_next = DONE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              i_next = i_reg + 1'b1;
            end
          end else begin
            j_next = j_reg + 1'b1;
          end
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One register per C element; each loads only when its index is committed.
  for (genvar gi = 0; gi < N * N; gi++) begin : g_out
    logic [DATA_W-1:0] elem_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        elem_reg <= '0;
      end else if (wr_en && (c_idx == ELEM_W'(gi))) begin
        elem_reg <= mac_result;
      end
    end

    assign bus.acc_out[gi] = elem_reg;
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_acc_matmul_core.sv
// Testbench for acc_matmul_core: two N=4 engines (SAT=0 and SAT=1) share one
// stimulus stream and are checked every cycle against a dot-product model;
// a default N=32 engine runs once on random data.
module tb_acc_matmul_core;
  import acc_pkg::*;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int NL = ACC_N;

  typedef logic [NS*NS-1:0][DW-1:0] mat4_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst   = 1'b1;
  logic  start = 1'b0;
  mat4_t a4    = '0;
  mat4_t b4    = '0;

  logic                       rst32   = 1'b1;
  logic                       start32 = 1'b0;
  logic [NL*NL-1:0][DW-1:0]   a32     = '0;
  logic [NL*NL-1:0][DW-1:0]   b32     = '0;

  acc_matmul_core_if #(.N(NS), .DATA_W(DW)) bus0 ();
  acc_matmul_core_if #(.N(NS), .DATA_W(DW)) bus1 ();
  acc_matmul_core_if #(.N(NL), .DATA_W(DW)) bus32 ();

  assign bus0.start     = start;
  assign bus0.acc_in_A  = a4;
  assign bus0.acc_in_B  = b4;
  assign bus1.start     = start;
  assign bus1.acc_in_A  = a4;
  assign bus1.acc_in_B  = b4;
  assign bus32.start    = start32;
  assign bus32.acc_in_A = a32;
  assign bus32.acc_in_B = b32;

  acc_matmul_core #(.N(NS), .DATA_W(DW), .SAT(0)) dut_s0 (.clk(clk), .rst(rst),   .bus(bus0));
  acc_matmul_core #(.N(NS), .DATA_W(DW), .SAT(1)) dut_s1 (.clk(clk), .rst(rst),   .bus(bus1));
  acc_matmul_core #(.N(NL), .DATA_W(DW), .SAT(0)) dut_32 (.clk(clk), .rst(rst32), .bus(bus32));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] out_rule(input int unsigned s, input bit sat);
    if (sat && s > 255) return 8'hff;
    return s[7:0];
  endfunction

  function automatic int unsigned dot4(input mat4_t a, input mat4_t b, input int i, input int j);
    int unsigned s = 0;
    for (int k = 0; k < NS; k++) s += int'(a[i*NS+k]) * int'(b[k*NS+j]);
    return s;
  endfunction

  // Behavioural model of the N=4 engines: phase 0 idle, 1 computing, 2 done.
  // During computing, the run's cycle count c = (i*N + j)*N + k; on the cycle
  // with k = N-1 element i*N+j takes its full dot product.
  bit    m_valid = 0;
  int    m_phase = 0;
  int    m_cnt   = 0;
  bit    m_sq    = 0;
  bit    m_busy  = 0;
  bit    m_done  = 0;
  mat4_t m_out0  = '0;
  mat4_t m_out1  = '0;

  // Compare process: at each falling edge check outputs against the model,
  // then advance the model with the inputs the next rising edge will sample.
  initial begin
    int          e;
    int unsigned s;
    bit          rise;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("busy_s0", bus0.busy,    m_busy);
        chk("done_s0", bus0.done,    m_done);
        chk("out_s0",  bus0.acc_out, m_out0);
        chk("busy_s1", bus1.busy,    m_busy);
        chk("done_s1", bus1.done,    m_done);
        chk("out_s1",  bus1.acc_out, m_out1);
      end
      if (rst) begin
        m_valid = 1; m_phase = 0; m_cnt = 0; m_sq = 0;
        m_busy = 0; m_done = 0; m_out0 = '0; m_out1 = '0;
      end else if (m_valid) begin
        rise   = start && !m_sq;
        m_sq   = start;
        m_done = 0;
        case (m_phase)
          0: if (rise) begin m_phase = 1; m_cnt = 0; m_busy = 1; end
          1: begin
            if (m_cnt % NS == NS - 1) begin
              e = m_cnt / NS;
              s = dot4(a4, b4, e / NS, e % NS);
              m_out0[e] = out_rule(s, 0);
              m_out1[e] = out_rule(s, 1);
            end
            m_cnt++;
            if (m_cnt == NS * NS * NS) begin m_phase = 2; m_busy = 0; m_done = 1; end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Call with start just raised; t counts rising edges from the launch edge.
  task automatic wait_done(input int limit, input bit drop, output int done_at, output int busy_n);
    done_at = -1;
    busy_n  = 0;
    for (int t = 1; t <= limit; t++) begin
      tick(1);
      if (drop && t == 1) start = 1'b0;
      if (bus0.busy) busy_n++;
      if (bus0.done) begin done_at = t; break; end
    end
  endtask

  task automatic run_uniform(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input logic [7:0] e0, input logic [7:0] e1);
    int    d, bn;
    mat4_t x0, x1;
    for (int e = 0; e < NS * NS; e++) begin a4[e] = av; b4[e] = bv; x0[e] = e0; x1[e] = e1; end
    start = 1'b1;
    wait_done(200, 1, d, bn);
    chk({name, "_done_cycle"}, d, 65);
    chk({name, "_wrap"}, bus0.acc_out, x0);
    chk({name, "_sat"},  bus1.acc_out, x1);
    tick(2);
  endtask

  initial begin
    int          d, bn, pulses;
    mat4_t       ex;
    int unsigned s;

    tick(2);
    chk("reset_busy", bus0.busy, 0);
    chk("reset_done", bus0.done, 0);
    chk("reset_out",  bus0.acc_out, 0);
    rst = 1'b0;
    tick(1);

    // Identity times a ramp reproduces the ramp.
    for (int r = 0; r < NS; r++)
      for (int c = 0; c < NS; c++) begin
        a4[r*NS+c] = (r == c) ? 8'd1 : 8'd0;
        b4[r*NS+c] = 8'(r * NS + c);
      end
    start = 1'b1;
    wait_done(200, 1, d, bn);
    chk("id_done_cycle",  d, 65);
    chk("id_busy_cycles", bn, 64);
    chk("id_out_s0", bus0.acc_out, b4);
    chk("id_out_s1", bus1.acc_out, b4);
    tick(2);

    run_uniform("k23",  8'd2,   8'd3,   8'd24, 8'd24);
    run_uniform("k16",  8'd16,  8'd16,  8'd0,  8'd255);
    run_uniform("k255", 8'd255, 8'd255, 8'd4,  8'd255);

    // Start held high for 200 cycles launches once.
    for (int e = 0; e < NS * NS; e++) begin a4[e] = 8'($urandom); b4[e] = 8'($urandom); end
    start = 1'b1;
    pulses = 0;
    for (int t = 0; t < 200; t++) begin tick(1); if (bus0.done) pulses++; end
    chk("hold_pulses", pulses, 1);
    start = 1'b0;
    tick(2);

    // Start toggling during the run is ignored.
    start = 1'b1;
    d = -1; pulses = 0;
    for (int t = 1; t <= 100; t++) begin
      tick(1);
      start = ((t >= 10 && t < 13) || (t >= 20 && t < 22)) ? 1'b1 : 1'b0;
      if (bus0.done) begin pulses++; if (d < 0) d = t; end
    end
    chk("toggle_done_cycle", d, 65);
    chk("toggle_pulses", pulses, 1);
    start = 1'b1;
    wait_done(200, 1, d, bn);
    chk("relaunch_done_cycle", d, 65);
    tick(2);

    // Reset 30 cycles into a run aborts it silently.
    for (int e = 0; e < NS * NS; e++) begin a4[e] = 8'($urandom); b4[e] = 8'($urandom); end
    start = 1'b1;
    bn = 0;
    for (int t = 1; t <= 100 && bn < 30; t++) begin
      tick(1);
      start = 1'b0;
      if (bus0.busy) bn++;
    end
    chk("pre_rst_busy_cycles", bn, 30);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_out_s0", bus0.acc_out, 0);
    chk("rst_out_s1", bus1.acc_out, 0);
    pulses = 0;
    for (int t = 0; t < 100; t++) begin tick(1); if (bus0.done) pulses++; end
    chk("rst_no_done", pulses, 0);

    // Start held through reset release launches one run; C[i][j] = j*(6i+14).
    for (int r = 0; r < NS; r++)
      for (int c = 0; c < NS; c++) begin
        a4[r*NS+c] = 8'(r + c);
        b4[r*NS+c] = 8'(r * c);
        ex[r*NS+c] = 8'(c * (6 * r + 14));
      end
    start = 1'b1;
    rst   = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_done(200, 0, d, bn);
    chk("rst_start_done_cycle", d, 65);
    chk("nonsq_out_s0", bus0.acc_out, ex);
    chk("nonsq_out_s1", bus1.acc_out, ex);
    start = 1'b0;
    tick(2);

    // Random data, verified cycle by cycle by the model.
    repeat (5) begin
      for (int e = 0; e < NS * NS; e++) begin a4[e] = 8'($urandom); b4[e] = 8'($urandom); end
      start = 1'b1;
      wait_done(200, 1, d, bn);
      chk("rand_done_cycle", d, 65);
      tick(3);
    end

    // Default geometry on random data.
    for (int e = 0; e < NL * NL; e++) begin a32[e] = 8'($urandom); b32[e] = 8'($urandom); end
    chk("n32_reset_busy", bus32.busy, 0);
    rst32 = 1'b0;
    tick(1);
    start32 = 1'b1;
    d = -1; bn = 0;
    for (int t = 1; t <= 40000; t++) begin
      tick(1);
      start32 = 1'b0;
      if (bus32.busy) bn++;
      if (bus32.done) begin d = t; break; end
    end
    chk("n32_done_cycle",  d, 32769);
    chk("n32_busy_cycles", bn, 32768);
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < NL; j++) begin
        s = 0;
        for (int k = 0; k < NL; k++) s += int'(a32[i*NL+k]) * int'(b32[k*NL+j]);
        chk($sformatf("n32_c%0d", i * NL + j), bus32.acc_out[i*NL+j], out_rule(s, 0));
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_matmul_core.md
Name: acc_matmul_core

Overview:
- Matrix-multiply engine directly downstream of the memory-mapped accelerator bridge. It consumes flat byte matrices A and B from the bridge and produces C = A x B back to it.
- Runs sequentially with one multiply-accumulate per cycle, so the design is small and timing-friendly at the cost of latency.
- Launched by the bridge's start level. A busy/done pair lets the bridge or firmware poll for completion.

Parameters:
- N, 32, matrix dimension; matrices are N x N; N*N must equal the bridge's matrix size (1024 at default).
- DATA_W, 8, element width for A, B and C.
- SAT, 0, output rule: 0 = keep low DATA_W bits of the sum (mod 2^DATA_W); 1 = clamp to 2^DATA_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request from the bridge (level; may stay high indefinitely).
- acc_in_A  in  [N*N-1:0][DATA_W-1:0]  matrix A, row-major: A[r][c] = acc_in_A[r*N+c].
- acc_in_B  in  [N*N-1:0][DATA_W-1:0]  matrix B, row-major.
- acc_out  out  [N*N-1:0][DATA_W-1:0]  matrix C, row-major, registered.
- busy  out  1  high while computing.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Single clock domain: all state updates on the rising edge of clk. rst is synchronous and active-high.
- Reset values:
  - state = IDLE; i = j = k = 0; accumulator = 0.
  - start_q = 0.
  - acc_out = all zeros; busy = 0; done = 0.
- Launch: a start rising edge is detected as start & ~start_q, where start_q is start registered every cycle.
  - Level-held start does not relaunch.
  - A start held high through reset release launches exactly one run, because start_q resets to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a rising edge: i = j = k = 0, busy <= 1.
  - RUN: one MAC per cycle: acc <= (k==0 ? 0 : acc) + A[i][k]*B[k][j].
  - Loop order: k innermost, then j, then i.
  - When k == N-1: acc_out[i*N+j] <= out_rule(full sum including this cycle's product). k wraps to 0, j increments; on j wrap, i increments.
  - RUN -> DONE on the cycle processing i = j = k = N-1: busy <= 0, done <= 1.
  - DONE -> IDLE unconditionally next cycle: done <= 0.
- Timing:
  - busy is high for exactly N^3 cycles (32768 at default).
  - done is high for exactly 1 cycle, immediately after busy falls.
  - Launch-edge-to-done latency is N^3 + 1 cycles.
- Arithmetic:
  - Operands are unsigned. Product width is 2*DATA_W.
  - Accumulator width ACC_W = 2*DATA_W + clog2(N), which never overflows.
  - out_rule applies the SAT rule above.
- acc_out updates one element per N cycles during RUN, so partially computed C is visible. Elements not yet recomputed hold their previous-run values. acc_out holds its value indefinitely in IDLE and DONE.
- Input stability: acc_in_A and acc_in_B are sampled live, not snapshotted. They must be stable while busy; changes during RUN corrupt only the elements computed after the change.
- start behaviour outside IDLE:
  - start rising during RUN or DONE is ignored, not queued.
  - start_q still tracks start, so a level held high across the end of a run does not relaunch.
- rst in any state, including mid-RUN: takes effect at that edge. The run is aborted, outputs return to their reset values, no done pulse is produced, and any completed elements are cleared.

Decomposition:
- Package acc_pkg:
  - Localparams ACC_N = 32 and ACC_DATA_W = 8, shared with the bridge so matrix geometry cannot diverge.
  - The state enum typedef (IDLE, RUN, DONE).
  - An acc_width function returning 2*DATA_W + $clog2(N).
- One sub-module, acc_mac_unit:
  - Inputs: operand pair, clear flag (k == 0), enable.
  - Outputs: registered accumulator plus a combinational out_rule result (truncate or clamp per SAT).
  - The top level keeps the FSM, counters, operand muxing and the acc_out register.

Test Plan (N=4, DATA_W=8 unless stated):
- Identity: A = I, B[r][c] = r*4+c; pulse start -> busy high for 64 cycles; done pulses once at cycle 65 after the launch edge; acc_out == B.
- Known product: A all 2, B all 3 -> every C element = 24; with A = B = all 16, SAT=0 -> every element = 1024 mod 256 = 0; SAT=1 -> every element = 255.
- Max operands: A = B = all 255, SAT=0 -> every element = (4*65025) mod 256 = 4; SAT=1 -> every element = 255; check the accumulator does not wrap.
- Start handling: hold start high for 200 cycles -> exactly one done pulse. Toggle start during RUN -> ignored; done still at cycle 65. Drop start and raise it again after done -> second run completes.
- Reset mid-run: assert rst at RUN cycle 30 -> next cycle busy = 0, done = 0, acc_out all zeros; no done pulse follows. Hold start high through reset release -> a fresh run launches and produces the correct C.
- Non-square values: A[r][c] = r+c, B[r][c] = r*c -> compare every element against a reference model. Also cover N=32 with random data: done at cycle 32769 and all 1024 elements match the model.
